// File: rtl/exc_unit.sv
// M-stage exception unit with integrated CP0 state (Status/Cause/EPC/BadVAddr/Count/Compare),
// timer interrupt and flush/redirect sequencing.
module exc_unit #(
  parameter int unsigned NUM_INT   = 6,
  parameter logic [31:0] EXC_VEC   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned TIMER_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_INT-1:0] ext_int,
  input  logic               validM,
  input  logic               stallM,
  input  logic [31:0]        pcM,
  input  logic               delayslotM,
  input  logic [31:0]        bad_addrM,
  input  logic               instadel,
  input  logic               adel,
  input  logic               ades,
  input  logic               syscall,
  input  logic               brk,
  input  logic               eret,
  input  logic               invalid,
  input  logic               overflow,
  input  logic               cp0weW,
  input  logic [4:0]         waddrW,
  input  logic [31:0]        wdataW,
  input  logic [4:0]         raddr,
  output logic [31:0]        rdata,
  output logic [31:0]        excepttypeM,
  output logic               flush,
  output logic [31:0]        newpc,
  output logic [31:0]        status_o,
  output logic [31:0]        cause_o,
  output logic [31:0]        epc_o,
  output logic               timer_int
);

  localparam int unsigned CNT_W = 3;
  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;

  localparam logic [31:0] EXC_INT  = 32'h1;
  localparam logic [31:0] EXC_ADEL = 32'h4;
  localparam logic [31:0] EXC_ADES = 32'h5;
  localparam logic [31:0] EXC_SYS  = 32'h8;
  localparam logic [31:0] EXC_BP   = 32'h9;
  localparam logic [31:0] EXC_RI   = 32'hA;
  localparam logic [31:0] EXC_OV   = 32'hC;
  localparam logic [31:0] EXC_ERET = 32'hE;

  typedef enum logic {S_IDLE, S_FLUSH} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic [31:0]      newpc_q, newpc_d;
  logic [7:0]       im_q, im_d;
  logic             exl_q, exl_d, ie_q, ie_d;
  logic [1:0]       ip_sw_q, ip_sw_d;
  logic [5:0]       ip_hw_q, ip_hw_d;
  logic             bd_q, bd_d;
  logic [4:0]       exccode_q, exccode_d;
  logic [31:0]      epc_q, epc_d, badvaddr_q, badvaddr_d;
  logic [31:0]      count_q, count_d, compare_q, compare_d;
  logic             phase_q, phase_d;
  logic             timer_q, timer_d;

  logic        timer_ip;
  logic [7:0]  ip_eff;
  logic [31:0] status_v, cause_v;
  logic        int_req, commit;

  // Architectural views of Status/Cause; IP7 also carries the timer interrupt.
  always_comb begin
    timer_ip = (TIMER_EN != 0) && timer_q;
    ip_eff   = {ip_hw_q[5] | timer_ip, ip_hw_q[4:0], ip_sw_q};
    status_v = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    cause_v  = {bd_q, 15'd0, ip_eff, 1'b0, exccode_q, 2'd0};
    int_req  = ((ip_eff & im_q) != 8'd0) && !exl_q && ie_q;
  end

  // Priority encoder; nothing is reported while a flush is in progress.
  always_comb begin
    excepttypeM = 32'd0;
    if (validM && state_q == S_IDLE) begin
      if (int_req)              excepttypeM = EXC_INT;
      else if (instadel || adel) excepttypeM = EXC_ADEL;
      else if (ades)            excepttypeM = EXC_ADES;
      else if (syscall)         excepttypeM = EXC_SYS;
      else if (brk)             excepttypeM = EXC_BP;
      else if (eret)            excepttypeM = EXC_ERET;
      else if (invalid)         excepttypeM = EXC_RI;
      else if (overflow)        excepttypeM = EXC_OV;
    end
    commit = (excepttypeM != 32'd0) && !stallM && (state_q == S_IDLE);
  end

  always_comb begin
    unique case (raddr)
      REG_BADVADDR: rdata = badvaddr_q;
      REG_COUNT:    rdata = count_q;
      REG_COMPARE:  rdata = compare_q;
      REG_STATUS:   rdata = status_v;
      REG_CAUSE:    rdata = cause_v;
      REG_EPC:      rdata = epc_q;
      default:      rdata = 32'd0;
    endcase
  end

  // Next state: MTC0 first, then commit overrides the fields it owns.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flush_d    = 1'b0;
    newpc_d    = newpc_q;
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = 6'(ext_int);
    bd_d       = bd_q;
    exccode_d  = exccode_q;
    epc_d      = epc_q;
    badvaddr_d = badvaddr_q;
    compare_d  = compare_q;
    count_d    = count_q;
    phase_d    = !phase_q;
    timer_d    = timer_q;

    if (cp0weW) begin
      unique case (waddrW)
        REG_STATUS: begin
          im_d  = wdataW[15:8];
          exl_d = wdataW[1];
          ie_d  = wdataW[0];
        end
        REG_CAUSE:   ip_sw_d   = wdataW[9:8];
        REG_EPC:     epc_d     = wdataW;
        REG_COMPARE: compare_d = wdataW;
        default: ;
      endcase
    end

    if (cp0weW && waddrW == REG_COUNT) begin
      count_d = wdataW;
      phase_d = 1'b0;
    end else if (phase_q) begin
      count_d = count_q + 32'd1;
    end

    if (cp0weW && waddrW == REG_COMPARE) timer_d = 1'b0;
    else if (count_d == compare_d)       timer_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (commit) begin
          if (excepttypeM == EXC_ERET) begin
            exl_d   = 1'b0;
            newpc_d = (cp0weW && waddrW == REG_EPC) ? wdataW : epc_q;
          end else begin
            if (!exl_q) begin
              epc_d = delayslotM ? pcM - 32'd4 : pcM;
              bd_d  = delayslotM;
            end
            exccode_d = (excepttypeM == EXC_INT) ? 5'd0 : excepttypeM[4:0];
            exl_d     = 1'b1;
            newpc_d   = EXC_VEC;
            if (excepttypeM == EXC_ADEL || excepttypeM == EXC_ADES)
              badvaddr_d = instadel ? pcM : bad_addrM;
          end
          state_d = S_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYC - 1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
    endcase

    flush_d = (state_d == S_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      flush_q    <= 1'b0;
      newpc_q    <= 32'd0;
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= 2'd0;
      ip_hw_q    <= 6'd0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      count_q    <= 32'd0;
      compare_q  <= 32'd0;
      phase_q    <= 1'b0;
      timer_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flush_q    <= flush_d;
      newpc_q    <= newpc_d;
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      bd_q       <= bd_d;
      exccode_q  <= exccode_d;
      epc_q      <= epc_d;
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      phase_q    <= phase_d;
      timer_q    <= timer_d;
    end
  end

  assign flush     = flush_q;
  assign newpc     = newpc_q;
  assign status_o  = status_v;
  assign cause_o   = cause_v;
  assign epc_o     = epc_q;
  assign timer_int = timer_q;

endmodule

// File: tb/tb_exc_unit.sv
// Bench for exc_unit: word-level CP0 model checked every cycle, plus directed literal checks.
module tb_exc_unit;

  localparam int FC = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;
  localparam logic [31:0] ST_WMASK = 32'h0000_FF03;
  localparam logic [31:0] CA_WMASK = 32'h0000_0300;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic        validM, stallM, delayslotM;
  logic [31:0] pcM, bad_addrM;
  logic        instadel, adel, ades, syscall, brk, eret, invalid, overflow;
  logic        cp0weW;
  logic [4:0]  waddrW, raddr;
  logic [31:0] wdataW;
  logic [31:0] rdata, excepttypeM, newpc, status_o, cause_o, epc_o;
  logic        flush, timer_int;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  exc_unit #(.NUM_INT(6), .EXC_VEC(VEC), .FLUSH_CYC(FC), .TIMER_EN(1)) dut (
    .clk(clk), .rst(rst), .ext_int(ext_int), .validM(validM), .stallM(stallM),
    .pcM(pcM), .delayslotM(delayslotM), .bad_addrM(bad_addrM),
    .instadel(instadel), .adel(adel), .ades(ades), .syscall(syscall), .brk(brk),
    .eret(eret), .invalid(invalid), .overflow(overflow),
    .cp0weW(cp0weW), .waddrW(waddrW), .wdataW(wdataW), .raddr(raddr), .rdata(rdata),
    .excepttypeM(excepttypeM), .flush(flush), .newpc(newpc),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state, kept as whole architectural words.
  logic [31:0] m_status = 32'h0040_0000, m_cause = 0, m_epc = 0, m_badv = 0;
  logic [31:0] m_count = 0, m_compare = 0, m_newpc = 0;
  logic [5:0]  m_ip_hw = 0;
  logic        m_timer = 0, m_phase = 0;
  int          m_left = 0;

  function automatic logic [31:0] m_cause_word();
    return m_cause | (32'({m_ip_hw[5] | m_timer, m_ip_hw[4:0]}) << 10);
  endfunction

  function automatic logic [31:0] m_exc();
    logic [31:0] cw;
    cw = m_cause_word();
    if (!validM || m_left != 0) return 32'h0;
    if ((cw[15:8] & m_status[15:8]) != 8'h0 && !m_status[1] && m_status[0]) return 32'h1;
    if (instadel || adel) return 32'h4;
    if (ades)     return 32'h5;
    if (syscall)  return 32'h8;
    if (brk)      return 32'h9;
    if (eret)     return 32'hE;
    if (invalid)  return 32'hA;
    if (overflow) return 32'hC;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_rdata();
    case (raddr)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause_word();
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model_upd
    logic [31:0] exc, n_status, n_cause, n_epc, n_count, n_compare, n_badv, n_newpc;
    logic        commit, n_timer, n_phase;
    if (!rst) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_badv = 0;
      m_count = 0; m_compare = 0; m_newpc = 0; m_ip_hw = 0;
      m_timer = 0; m_phase = 0; m_left = 0;
    end else begin
      exc = m_exc();
      commit = (exc != 0) && !stallM && (m_left == 0);
      n_status = m_status; n_cause = m_cause; n_epc = m_epc; n_compare = m_compare;
      n_badv = m_badv; n_newpc = m_newpc; n_timer = m_timer;
      n_count = m_count; n_phase = m_phase;
      if (cp0weW && waddrW == 5'd9) begin
        n_count = wdataW; n_phase = 1'b0;
      end else begin
        if (m_phase) n_count = m_count + 1;
        n_phase = !m_phase;
      end
      if (cp0weW) begin
        case (waddrW)
          5'd11: n_compare = wdataW;
          5'd12: n_status  = (m_status & ~ST_WMASK) | (wdataW & ST_WMASK);
          5'd13: n_cause   = (m_cause & ~CA_WMASK) | (wdataW & CA_WMASK);
          5'd14: n_epc     = wdataW;
          default: ;
        endcase
      end
      if (cp0weW && waddrW == 5'd11) n_timer = 1'b0;
      else if (n_count == n_compare) n_timer = 1'b1;
      if (commit) begin
        if (exc == 32'hE) begin
          n_status[1] = 1'b0;
          n_newpc = n_epc;
        end else begin
          if (!m_status[1]) begin
            n_epc = delayslotM ? pcM - 32'd4 : pcM;
            n_cause[31] = delayslotM;
          end
          n_cause[6:2] = (exc == 32'h1) ? 5'd0 : exc[4:0];
          n_status[1] = 1'b1;
          n_newpc = VEC;
          if (exc == 32'h4 || exc == 32'h5) n_badv = instadel ? pcM : bad_addrM;
        end
      end
      m_left = (m_left != 0) ? m_left - 1 : (commit ? FC : 0);
      m_status = n_status; m_cause = n_cause; m_epc = n_epc; m_compare = n_compare;
      m_badv = n_badv; m_newpc = n_newpc; m_timer = n_timer;
      m_count = n_count; m_phase = n_phase; m_ip_hw = ext_int;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("excepttypeM", excepttypeM, m_exc());
      chk("flush", 32'(flush), 32'(m_left != 0));
      chk("newpc", newpc, m_newpc);
      chk("status", status_o, m_status);
      chk("cause", cause_o, m_cause_word());
      chk("epc", epc_o, m_epc);
      chk("timer_int", 32'(timer_int), 32'(m_timer));
      chk("rdata", rdata, m_rdata());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    validM = 0; stallM = 0; delayslotM = 0; pcM = 0; bad_addrM = 0;
    instadel = 0; adel = 0; ades = 0; syscall = 0; brk = 0; eret = 0;
    invalid = 0; overflow = 0; cp0weW = 0; waddrW = 0; wdataW = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    cp0weW = 1; waddrW = a; wdataW = d;
    step();
    cp0weW = 0; waddrW = 0; wdataW = 0;
  endtask

  initial begin : stim
    int n;
    rst = 0; ext_int = 0; raddr = 5'd12;
    clr();
    step();
    chk_en = 1'b1;
    chk("lit_rst_status", status_o, 32'h0040_0000);
    chk("lit_rst_cause", cause_o, 32'h0);
    chk("lit_rst_flush", 32'(flush), 32'h0);
    chk("lit_rst_newpc", newpc, 32'h0);
    rst = 1;
    mtc0(5'd11, 32'hFFFF_0000);

    // overflow, not in a delay slot
    validM = 1; overflow = 1; pcM = 32'h8000_0100;
    #1 chk("lit_ov_code", excepttypeM, 32'hC);
    step();
    #1 chk("lit_busy_code", excepttypeM, 32'h0);
    clr();
    chk("lit_ov_epc", epc_o, 32'h8000_0100);
    chk("lit_ov_cause", cause_o, 32'h0000_0030);
    chk("lit_ov_status", status_o, 32'h0040_0002);
    chk("lit_ov_flush", 32'(flush), 32'h1);
    chk("lit_ov_newpc", newpc, VEC);
    step();
    chk("lit_ov_flush2", 32'(flush), 32'h1);
    step();
    chk("lit_ov_flush_end", 32'(flush), 32'h0);

    // AdEL in a delay slot, then ERET
    mtc0(5'd12, 32'h0);
    validM = 1; adel = 1; delayslotM = 1; pcM = 32'h8000_0204; bad_addrM = 32'h1001;
    step();
    clr();
    raddr = 5'd8;
    #1;
    chk("lit_adel_epc", epc_o, 32'h8000_0200);
    chk("lit_adel_bd", 32'(cause_o[31]), 32'h1);
    chk("lit_adel_badv", rdata, 32'h0000_1001);
    raddr = 5'd12;
    repeat (FC) step();
    validM = 1; eret = 1;
    step();
    clr();
    chk("lit_eret_newpc", newpc, 32'h8000_0200);
    chk("lit_eret_exl", 32'(status_o[1]), 32'h0);
    repeat (FC) step();

    // syscall beats invalid; second syscall with EXL=1 keeps EPC
    validM = 1; syscall = 1; invalid = 1; pcM = 32'h8000_0300;
    #1 chk("lit_sys_code", excepttypeM, 32'h8);
    step();
    clr();
    chk("lit_sys_epc", epc_o, 32'h8000_0300);
    repeat (FC) step();
    validM = 1; syscall = 1; pcM = 32'h8000_0500;
    step();
    clr();
    chk("lit_sys_exl_epc", epc_o, 32'h8000_0300);
    repeat (FC) step();

    // MTC0 EPC on the same edge as ERET
    validM = 1; eret = 1; cp0weW = 1; waddrW = 5'd14; wdataW = 32'h8000_0400;
    step();
    clr();
    chk("lit_fwd_newpc", newpc, 32'h8000_0400);
    repeat (FC) step();

    // stalled exception never commits
    validM = 1; stallM = 1; overflow = 1; pcM = 32'h8000_0700;
    step();
    chk("lit_stall_flush", 32'(flush), 32'h0);
    step();
    clr();
    chk("lit_stall_epc", epc_o, 32'h8000_0400);

    // external interrupt on IP2 outranks overflow
    mtc0(5'd12, 32'h0000_0401);
    ext_int = 6'b000001;
    step();
    validM = 1; overflow = 1; pcM = 32'h8000_0600;
    #1 chk("lit_int_code", excepttypeM, 32'h1);
    step();
    clr();
    ext_int = 0;
    chk("lit_int_epc", epc_o, 32'h8000_0600);
    chk("lit_int_exccode", cause_o & 32'h7C, 32'h0);
    repeat (FC) step();

    // timer interrupt: Count=0, Compare=10, Status=IM7|IE
    mtc0(5'd9, 32'h0);
    n = 0;
    mtc0(5'd11, 32'd10); n++;
    mtc0(5'd12, 32'h0000_8001); n++;
    while (!timer_int && n < 40) begin
      step();
      n++;
    end
    chk("lit_timer_cycles", 32'(n), 32'd20);
    raddr = 5'd9;
    #1 chk("lit_timer_count", rdata, 32'd10);
    raddr = 5'd12;
    validM = 1; stallM = 1;
    #1 chk("lit_timer_code", excepttypeM, 32'h1);
    mtc0(5'd11, 32'hFFFF_FFF0);
    chk("lit_timer_clr", 32'(timer_int), 32'h0);
    clr();

    // reset in the middle of a flush
    validM = 1; overflow = 1; pcM = 32'h8000_0800;
    step();
    clr();
    chk("lit_rf_flush", 32'(flush), 32'h1);
    rst = 0;
    step();
    chk("lit_rf_flush0", 32'(flush), 32'h0);
    chk("lit_rf_status", status_o, 32'h0040_0000);
    chk("lit_rf_epc", epc_o, 32'h0);
    rst = 1;
    repeat (3) step();

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
